// File: rtl/trace_input_queue_if.sv
// Handshake/data bundle for trace_input_queue: push side, pop side, config bus and status.
interface trace_input_queue_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 4,
  parameter int CHAIN_W    = 1
);
  localparam int CW = $clog2(IB_DEPTH + 1);

  logic                  enqueue;
  logic                  tracing;
  logic                  eof_in;
  logic [CHAIN_W-1:0]    chainId_in;
  logic [DATA_WIDTH-1:0] vector_in [N];
  logic                  dequeue;
  logic [7:0]            configId;
  logic [7:0]            configData;

  logic                  valid_out;
  logic [DATA_WIDTH-1:0] vector_out [N];
  logic                  eof_out;
  logic [CHAIN_W-1:0]    chainId_out;
  logic [CW-1:0]         count_out;
  logic                  full_out;
  logic                  empty_out;
  logic                  almost_full_out;
  logic [15:0]           drop_count_out;

  modport master (
    output enqueue, tracing, eof_in, chainId_in, vector_in, dequeue, configId, configData,
    input  valid_out, vector_out, eof_out, chainId_out, count_out,
           full_out, empty_out, almost_full_out, drop_count_out
  );

  modport slave (
    input  enqueue, tracing, eof_in, chainId_in, vector_in, dequeue, configId, configData,
    output valid_out, vector_out, eof_out, chainId_out, count_out,
           full_out, empty_out, almost_full_out, drop_count_out
  );
endinterface

// File: rtl/trace_input_queue.sv
// Circular queue of N-lane vectors with eof/chain ID, 1-cycle registered pop and occupancy flags.
// Define TRACE_INPUT_QUEUE_DROP_CNT_EN to build the saturating rejected-push counter.
module trace_input_queue #(
  parameter int         N          = 8,
  parameter int         DATA_WIDTH = 32,
  parameter int         IB_DEPTH   = 4,
  parameter int         CHAIN_W    = 1,
  parameter logic [7:0] CFG_ID     = 8'h01
) (
  input logic                  clk,
  input logic                  reset,
  trace_input_queue_if.slave   q_if
);
  localparam int VW = N * DATA_WIDTH;
  localparam int EW = VW + 1 + CHAIN_W;
  localparam int PW = $clog2(IB_DEPTH);
  localparam int CW = $clog2(IB_DEPTH + 1);
  localparam logic [7:0]    AF_RST   = (IB_DEPTH > 255) ? 8'hFF : 8'(IB_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(IB_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(IB_DEPTH);

  logic [EW-1:0]      mem_q [IB_DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [7:0]         af_thr_q, af_thr_d;
  logic               empty_q, full_q, af_q;
  logic               valid_q;
  logic               eof_q, eof_d;
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [VW-1:0]      vec_q;
  logic               push, pop;
  logic [EW-1:0]      wr_word, rd_word;

  assign pop     = q_if.dequeue & ~empty_q;
  // A full queue still accepts a push when the same cycle frees a slot.
  assign push    = q_if.enqueue & q_if.tracing & (~full_q | pop);
  assign rd_word = mem_q[rd_ptr_q];

  always_comb begin
    wr_word = '0;
    wr_word[EW-1]              = q_if.eof_in;
    wr_word[EW-2 -: CHAIN_W]   = q_if.chainId_in;
    for (int i = 0; i < N; i++) begin
      wr_word[i*DATA_WIDTH +: DATA_WIDTH] = q_if.vector_in[i];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_thr_d = af_thr_q;
    eof_d    = 1'b0;
    chain_d  = '0;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      eof_d    = rd_word[EW-1];
      chain_d  = rd_word[EW-2 -: CHAIN_W];
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    if (q_if.configId == CFG_ID) af_thr_d = q_if.configData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_thr_q <= AF_RST;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      valid_q  <= 1'b0;
      eof_q    <= 1'b0;
      chain_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_thr_q <= af_thr_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CNT_FULL);
      af_q     <= (32'(count_d) >= 32'(af_thr_d));
      valid_q  <= pop;
      eof_q    <= eof_d;
      chain_q  <= chain_d;
    end
  end

  // Storage and output vector carry no reset; the vector is meaningless while valid is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_word;
    if (pop)  vec_q <= rd_word[VW-1:0];
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      q_if.vector_out[i] = vec_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign q_if.valid_out       = valid_q;
  assign q_if.eof_out         = eof_q;
  assign q_if.chainId_out     = chain_q;
  assign q_if.count_out       = count_q;
  assign q_if.empty_out       = empty_q;
  assign q_if.full_out        = full_q;
  assign q_if.almost_full_out = af_q;

`ifdef TRACE_INPUT_QUEUE_DROP_CNT_EN
  logic [15:0] drop_q;
  logic        drop;

  assign drop = q_if.enqueue & q_if.tracing & ~push;

  always_ff @(posedge clk) begin
    if (reset)                           drop_q <= '0;
    else if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign q_if.drop_count_out = drop_q;
`else
  assign q_if.drop_count_out = 16'h0000;
`endif
endmodule

// File: tb/tb_trace_input_queue.sv
// Randomized bench for trace_input_queue: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_trace_input_queue;
  localparam int N     = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 5;
`ifdef TRACE_INPUT_QUEUE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  typedef struct packed {
    logic         eof;
    logic [0:0]   chain;
    logic [255:0] vec;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  trace_input_queue_if #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .CHAIN_W(1)) qif ();

  trace_input_queue #(
    .N(N), .DATA_WIDTH(DW), .IB_DEPTH(DEPTH), .CHAIN_W(1), .CFG_ID(8'h01)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .q_if (qif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries, updated with the inputs seen at each rising edge.
  ent_t         m_q[$];
  ent_t         m_e;
  bit           model_ready = 1'b0;
  bit           m_valid, m_eof, m_pop, m_push, m_want;
  logic [0:0]   m_chain;
  logic [255:0] m_vec;
  int           m_drop, m_thr;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_valid = 1'b0; m_eof = 1'b0; m_chain = 1'b0;
      m_drop = 0; m_thr = DEPTH; model_ready = 1'b1;
    end else if (model_ready) begin
      m_pop  = qif.dequeue && (m_q.size() > 0);
      m_want = qif.enqueue && qif.tracing;
      m_push = m_want && ((m_q.size() < DEPTH) || m_pop);
      m_valid = m_pop; m_eof = 1'b0; m_chain = 1'b0;
      if (m_pop) begin
        m_e = m_q.pop_front();
        m_vec = m_e.vec; m_eof = m_e.eof; m_chain = m_e.chain;
      end
      if (m_push) begin
        m_e.eof = qif.eof_in;
        m_e.chain = qif.chainId_in;
        for (int i = 0; i < N; i++) m_e.vec[i*DW +: DW] = qif.vector_in[i];
        m_q.push_back(m_e);
      end
      if (DROP_EN && m_want && !m_push && m_drop < 65535) m_drop++;
      if (qif.configId == 8'h01) m_thr = int'(qif.configData);
    end
  end

  logic [255:0] d_vec;
  always @(negedge clk) begin
    if (model_ready) begin
      chk("count", qif.count_out, m_q.size());
      chk("empty", qif.empty_out, m_q.size() == 0);
      chk("full", qif.full_out, m_q.size() == DEPTH);
      chk("almost_full", qif.almost_full_out, m_q.size() >= m_thr);
      chk("valid", qif.valid_out, m_valid);
      chk("eof", qif.eof_out, m_eof);
      chk("chainId", qif.chainId_out, m_chain);
      chk("drop_count", qif.drop_count_out, m_drop);
      if (m_valid) begin
        for (int i = 0; i < N; i++) d_vec[i*DW +: DW] = qif.vector_out[i];
        chk("vector", d_vec, m_vec);
      end
    end
  end

  task automatic cyc(input bit enq, input bit trc, input bit deq, input bit eof, input bit ch,
                     input logic [31:0] l0, input logic [7:0] cid = 8'h00,
                     input logic [7:0] cdat = 8'h00, input bit rst = 1'b0);
    reset = rst;
    qif.enqueue = enq; qif.tracing = trc; qif.dequeue = deq;
    qif.eof_in = eof; qif.chainId_in = ch;
    qif.configId = cid; qif.configData = cdat;
    qif.vector_in[0] = l0;
    for (int i = 1; i < N; i++) qif.vector_in[i] = $urandom;
    @(negedge clk);
  endtask

  int drop_exp;

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    cyc(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("rst_count", qif.count_out, 0);
    chk("rst_empty", qif.empty_out, 1);
    chk("rst_valid", qif.valid_out, 0);
    chk("rst_af", qif.almost_full_out, 0);

    // Fill then drain in order.
    for (int i = 1; i <= 5; i++) cyc(1, 1, 0, 0, 0, i);
    chk("fill_full", qif.full_out, 1);
    chk("fill_count", qif.count_out, 5);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("drain_valid", qif.valid_out, 1);
      chk("drain_lane0", qif.vector_out[0], i);
    end
    cyc(0, 1, 0, 0, 0, 0);
    chk("drain_idle_valid", qif.valid_out, 0);
    chk("drain_empty", qif.empty_out, 1);

    // Full: push-only is dropped, push+pop is accepted.
    for (int i = 1; i <= 5; i++) cyc(1, 1, 0, 0, 0, 10 + i);
    drop_exp = DROP_EN ? 1 : 0;
    cyc(1, 1, 0, 0, 0, 99);
    chk("full_drop_count", qif.count_out, 5);
    chk("full_drop_cnt", qif.drop_count_out, drop_exp);
    cyc(1, 1, 1, 0, 0, 16);
    chk("full_pp_count", qif.count_out, 5);
    chk("full_pp_drop", qif.drop_count_out, drop_exp);
    chk("full_pp_lane0", qif.vector_out[0], 11);
    for (int i = 12; i <= 16; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("full_drain_lane0", qif.vector_out[0], i);
    end
    cyc(0, 1, 0, 0, 0, 0);

    // Interleaved pushes and pops to exercise pointer wrap.
    for (int k = 0; k < 12; k++) cyc(1, 1, (k % 3) != 0, 0, 0, 100 + k);
    for (int k = 0; k < 6; k++) cyc(0, 1, 1, 0, 0, 0);

    // eof / chain ID travel with their own entry only.
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 1, 1, 2);
    cyc(1, 1, 0, 0, 0, 3);
    cyc(0, 1, 1, 0, 0, 0);
    chk("eof_n1", qif.eof_out, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("eof_hit", qif.eof_out, 1);
    chk("chain_hit", qif.chainId_out, 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("eof_n2", qif.eof_out, 0);
    chk("chain_n2", qif.chainId_out, 0);

    // Push while not tracing is ignored and not a drop.
    cyc(1, 0, 0, 0, 0, 55);
    chk("notrace_count", qif.count_out, 0);
    chk("notrace_drop", qif.drop_count_out, drop_exp);

    // Almost-full threshold.
    cyc(0, 1, 0, 0, 0, 0, 8'h01, 8'd3);
    cyc(1, 1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0, 2);
    chk("af_at2", qif.almost_full_out, 0);
    cyc(1, 1, 0, 0, 0, 3);
    chk("af_at3", qif.almost_full_out, 1);
    cyc(0, 1, 1, 0, 0, 0);
    chk("af_back2", qif.almost_full_out, 0);
    cyc(0, 1, 0, 0, 0, 0, 8'h02, 8'd0);
    chk("af_other_id", qif.almost_full_out, 0);
    cyc(1, 1, 0, 0, 0, 4);
    chk("af_again3", qif.almost_full_out, 1);

    // Reset mid-traffic with a pop in flight.
    cyc(1, 1, 1, 0, 0, 5);
    cyc(0, 1, 1, 0, 0, 0, 8'h00, 8'h00, 1);
    chk("mrst_count", qif.count_out, 0);
    chk("mrst_valid", qif.valid_out, 0);
    chk("mrst_empty", qif.empty_out, 1);
    chk("mrst_drop", qif.drop_count_out, 0);
    cyc(1, 1, 0, 0, 0, 32'hA1);
    cyc(1, 1, 0, 0, 0, 32'hA2);
    cyc(1, 1, 0, 0, 0, 32'hA3);
    chk("mrst_thr_restored", qif.almost_full_out, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("mrst_lane0", qif.vector_out[0], 32'hA1);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      automatic int r = $urandom_range(0, 15);
      automatic logic [7:0] cid = (r == 0) ? 8'h01 : ((r == 1) ? 8'h02 : 8'h00);
      cyc($urandom_range(0, 1), $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom, cid,
          8'($urandom_range(0, 6)), $urandom_range(0, 127) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_input_queue.md
# trace_input_queue

Parametrised successor to the current input buffer stage at the head of the tracing pipeline: a circular queue of N-lane vectors that stores `eof` and chain ID per entry, supports any depth, and pops on an explicit downstream request. It reports occupancy and a runtime-configurable almost-full flag so upstream logic can throttle. An optional drop counter is compiled in by macro.

## Interface
- `N`, 8, vector lanes
- `DATA_WIDTH`, 32, bits per lane
- `IB_DEPTH`, 4, entries; any value ≥2, not restricted to powers of two
- `CHAIN_W`, 1, chain ID width
- `CFG_ID`, 8'h01, `configId` value that selects this block's threshold register
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `enqueue`  in  1  push request
- `tracing`  in  1  push gate; pushes ignored while low
- `eof_in`  in  1  end-of-frame flag stored with the entry
- `chainId_in`  in  CHAIN_W  chain ID stored with the entry
- `vector_in`  in  DATA_WIDTH×[N]  unpacked lane array
- `dequeue`  in  1  pop request from downstream
- `configId`, `configData`  in  8 each  configuration bus
- `valid_out`  out  1  `vector_out`/`eof_out`/`chainId_out` hold a popped entry this cycle
- `vector_out`  out  DATA_WIDTH×[N]  popped vector
- `eof_out`  out  1  popped eof
- `chainId_out`  out  CHAIN_W  popped chain ID
- `count_out`  out  $clog2(IB_DEPTH+1)  current occupancy
- `full_out`, `empty_out`, `almost_full_out`  out  1  status flags
- `drop_count_out`  out  16  pushes rejected (see Configuration)

## Operation
- Storage: one dual-port RAM, IB_DEPTH entries, entry width N·DATA_WIDTH+1+CHAIN_W; port A writes, port B reads.
- Pointers `wr_ptr`, `rd_ptr` in [0, IB_DEPTH-1]; each wraps from IB_DEPTH-1 to 0 on advance.
- Occupancy register `count` is authoritative: `empty_out = (count==0)`, `full_out = (count==IB_DEPTH)`. Flags never derive from pointer differences.
- `pop = dequeue & ~empty_out`.
- `push = enqueue & tracing & (~full_out | pop)`. A push is accepted when full if a pop occurs in the same cycle.
- Updates: push only gives count+1; pop only gives count−1; push and pop together leave count unchanged and advance both pointers.
- Enqueue on an empty queue with `dequeue` high in the same cycle: no pop and no bypass. The entry is poppable from the next cycle.
- Rejected push (`enqueue & tracing & ~push`): RAM and pointers untouched; counted as a drop (macro).
- `enqueue` while `tracing` is low: ignored and not counted as a drop.
- Threshold register `af_thr` (8 bits, reset value IB_DEPTH saturated to 255): written with `configData` when `configId==CFG_ID`. Any other `configId` is ignored.
- `almost_full_out = (count >= af_thr)`. With `af_thr==0` the flag is permanently high.

## Timing
- Write: the RAM is written at the clock edge ending the push cycle.
- Read latency is 1 cycle. A pop in cycle t gives `valid_out=1` with that entry's data, eof and chainId in cycle t+1.
- `valid_out` is a single-cycle pulse per pop. Back-to-back pops give back-to-back valid cycles. There is no backpressure on the output.
- Status outputs (`count_out`, all flags) are registered and reflect the state after the last edge.
- Reset (any cycle, including mid-burst):
  - pointers, `count`, `valid_out`, `eof_out`, `chainId_out`, and `drop_count_out` go to 0
  - `empty_out=1`, `full_out=0`, `almost_full_out=0`, `af_thr=IB_DEPTH`
  - `vector_out` content is don't-care while `valid_out=0`
  - RAM contents are not cleared; a pop issued in the reset cycle is discarded

## Configuration
- Macro `TRACE_INPUT_QUEUE_DROP_CNT_EN`.
- Defined: `drop_count_out` is a 16-bit counter, incremented once per rejected push and saturating at 16'hFFFF. Cleared only by reset.
- Undefined: no counter logic is built and `drop_count_out` is tied to 0.

## Test plan
- IB_DEPTH=5. Push 5 vectors (lane0 = 1..5) with `dequeue` low → `full_out=1`, `count_out=5`. Then pop 5 → `valid_out` on 5 consecutive cycles, each one cycle after its pop, lane0 = 1,2,3,4,5, then `empty_out=1`.
- Wrap-around: 12 pushes interleaved with pops on IB_DEPTH=5 → output order matches input. Every pointer wraps 4→0 with no loss.
- Full with simultaneous push+pop → push accepted, `count_out` stays 5, no drop. Full with push only → drop counted (macro on: `drop_count_out=1`; macro off: 0), data unchanged.
- Entry pushed with `eof_in=1`, `chainId_in=1` → `eof_out=1`, `chainId_out=1` only on that entry's `valid_out` cycle, and 0 on its neighbours. Push with `tracing=0` → no entry and no drop.
- `configId=CFG_ID`, `configData=3` → `almost_full_out` rises when `count_out` goes from 2 to 3 and falls when it returns to 2. `configId=8'h02` leaves the threshold unchanged.
- Assert `reset` with 3 entries queued and a pop in flight → next cycle `count_out=0`, `valid_out=0`, `empty_out=1`, `af_thr` restored. The first subsequent push/pop returns the new data.
